// File: rtl/keyed_fsm_pkg.sv
// Shared types and constants for the key-locked sequence controller.
// Duplicate states mirror the originals; DUP_MODE picks whether they corrupt.
package keyed_fsm_pkg;

    localparam int STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 4'd0,
        LOAD   = 4'd1,
        RUN    = 4'd2,
        HOLD   = 4'd3,
        DONE   = 4'd4,
        LOAD_D = 4'd5,
        RUN_D  = 4'd6,
        HOLD_D = 4'd7,
        DONE_D = 4'd8
    } state_e;

    localparam logic [1:0] GATE_START = 2'd0;
    localparam logic [1:0] GATE_RUN   = 2'd1;
    localparam logic [1:0] GATE_HOLD  = 2'd2;
    localparam logic [1:0] GATE_DONE  = 2'd3;

    localparam int DUP_EQUIV   = 0;
    localparam int DUP_CORRUPT = 1;

    function automatic logic isDup(state_e s);
        return (s == LOAD_D) || (s == RUN_D) || (s == HOLD_D) || (s == DONE_D);
    endfunction

endpackage

// File: rtl/key_gate_sel.sv
// Picks the original or duplicate successor of one key-gated transition.
// Gates at or above KEY_W have no key bit and always take the original.
module key_gate_sel
    import keyed_fsm_pkg::*;
#(
    parameter int         KEY_W       = 4,
    parameter logic [3:0] CORRECT_KEY = 4'b1010
) (
    input  logic [KEY_W-1:0]   keyinput_i,
    input  logic [1:0]         gate_idx_i,
    input  logic [STATE_W-1:0] orig_i,
    input  logic [STATE_W-1:0] dup_i,
    output logic [STATE_W-1:0] next_o
);

    logic [3:0] keyExt;
    logic [3:0] gateExists;
    logic       divert;

    always_comb begin
        keyExt     = '0;
        gateExists = '0;
        for (int i = 0; i < KEY_W; i++) begin
            keyExt[i]     = keyinput_i[i];
            gateExists[i] = 1'b1;
        end
        divert = gateExists[gate_idx_i] & (keyExt[gate_idx_i] ^ CORRECT_KEY[gate_idx_i]);
        next_o = divert ? dup_i : orig_i;
    end

endmodule

// File: rtl/keyed_seq_ctrl_dup.sv
// Start/length/pause countdown controller whose transitions are key-locked.
// Wrong key bits divert into duplicate states, which may corrupt cnt_out.
module keyed_seq_ctrl_dup
    import keyed_fsm_pkg::*;
#(
    parameter int         KEY_W        = 4,
    parameter logic [3:0] CORRECT_KEY  = 4'b1010,
    parameter int         CNT_W        = 8,
    parameter int         DUP_MODE     = 0,
    parameter logic [7:0] CORRUPT_MASK = 8'h5A
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] keyinput,
    input  logic             start,
    input  logic             pause,
    input  logic [CNT_W-1:0] len_in,
    output logic             busy,
    output logic             step,
    output logic             done,
    output logic [CNT_W-1:0] cnt_out
);

    localparam logic [CNT_W-1:0] MASK = CNT_W'(CORRUPT_MASK);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STATE_W-1:0] startNext, runNext, holdNext, doneNext;

    key_gate_sel #(.KEY_W(KEY_W), .CORRECT_KEY(CORRECT_KEY)) uGateStart (
        .keyinput_i(keyinput), .gate_idx_i(GATE_START),
        .orig_i(LOAD), .dup_i(LOAD_D), .next_o(startNext)
    );

    key_gate_sel #(.KEY_W(KEY_W), .CORRECT_KEY(CORRECT_KEY)) uGateRun (
        .keyinput_i(keyinput), .gate_idx_i(GATE_RUN),
        .orig_i(RUN), .dup_i(RUN_D), .next_o(runNext)
    );

    key_gate_sel #(.KEY_W(KEY_W), .CORRECT_KEY(CORRECT_KEY)) uGateHold (
        .keyinput_i(keyinput), .gate_idx_i(GATE_HOLD),
        .orig_i(HOLD), .dup_i(HOLD_D), .next_o(holdNext)
    );

    key_gate_sel #(.KEY_W(KEY_W), .CORRECT_KEY(CORRECT_KEY)) uGateDone (
        .keyinput_i(keyinput), .gate_idx_i(GATE_DONE),
        .orig_i(DONE), .dup_i(DONE_D), .next_o(doneNext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Zero count wins over pause, so a paused sequence at zero still finishes.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = state_e'(startNext);
            end
            LOAD, LOAD_D: begin
                cnt_d   = len_in;
                state_d = state_e'(runNext);
            end
            RUN, RUN_D: begin
                if (cnt_q == '0)  state_d = state_e'(doneNext);
                else if (pause)   state_d = state_e'(holdNext);
                else              cnt_d   = cnt_q - ONE;
            end
            HOLD, HOLD_D: begin
                if (!pause) state_d = state_e'(runNext);
            end
            DONE: state_d = IDLE;
            DONE_D: state_d = (DUP_MODE == DUP_CORRUPT) ? LOAD : IDLE;
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy    = (state_q == LOAD) || (state_q == RUN) || (state_q == HOLD) ||
                  (state_q == LOAD_D) || (state_q == RUN_D) || (state_q == HOLD_D);
        step    = ((state_q == RUN) || (state_q == RUN_D)) && (cnt_q != '0);
        done    = (state_q == DONE) || (state_q == DONE_D);
        cnt_out = ((DUP_MODE == DUP_CORRUPT) && isDup(state_q)) ? (cnt_q ^ MASK) : cnt_q;
    end

endmodule

// File: tb/tb_keyed_seq_ctrl_dup.sv
// Bench for keyed_seq_ctrl_dup: an equivalent-duplicate and a corrupting-duplicate
// instance share stimulus; a per-cycle model feeds a scoreboard alongside scenario checks.
module tb_keyed_seq_ctrl_dup;

    localparam logic [3:0] KEY_OK = 4'b1010;
    localparam logic [7:0] MASK   = 8'h5A;

    typedef struct packed {
        logic       busy;
        logic       step;
        logic       done;
        logic [7:0] cnt;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] keyinput = KEY_OK;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic [7:0] len_in = 8'd0;

    logic       busy0, step0, done0;
    logic [7:0] cnt0;
    logic       busy1, step1, done1;
    logic [7:0] cnt1;

    int   vectors = 0;
    int   miscompares = 0;
    bit   scoreOn = 1'b0;
    obs_t expQ0[$];
    obs_t expQ1[$];

    int       mSt[2];
    bit       mDp[2];
    logic [7:0] mCn[2];

    always #5 clk = ~clk;

    keyed_seq_ctrl_dup #(.KEY_W(4), .CORRECT_KEY(KEY_OK), .CNT_W(8), .DUP_MODE(0), .CORRUPT_MASK(MASK)) dut0 (
        .clk(clk), .rst(rst), .keyinput(keyinput), .start(start), .pause(pause), .len_in(len_in),
        .busy(busy0), .step(step0), .done(done0), .cnt_out(cnt0)
    );

    keyed_seq_ctrl_dup #(.KEY_W(4), .CORRECT_KEY(KEY_OK), .CNT_W(8), .DUP_MODE(1), .CORRUPT_MASK(MASK)) dut1 (
        .clk(clk), .rst(rst), .keyinput(keyinput), .start(start), .pause(pause), .len_in(len_in),
        .busy(busy1), .step(step1), .done(done1), .cnt_out(cnt1)
    );

    function automatic bit wrongBit(int i);
        return keyinput[i] != KEY_OK[i];
    endfunction

    // Model states: 0 idle, 1 load, 2 run, 3 hold, 4 done; mDp marks the duplicate copy.
    task automatic modelEdge(input int m);
        int         st = mSt[m];
        bit         dp = mDp[m];
        logic [7:0] c  = mCn[m];
        obs_t       e;
        if (rst) begin
            st = 0; dp = 0; c = 8'd0;
        end else begin
            case (st)
                0: if (start) begin st = 1; dp = wrongBit(0); end
                1: begin c = len_in; st = 2; dp = wrongBit(1); end
                2: begin
                    if (c == 8'd0)  begin st = 4; dp = wrongBit(3); end
                    else if (pause) begin st = 3; dp = wrongBit(2); end
                    else c = c - 8'd1;
                end
                3: if (!pause) begin st = 2; dp = wrongBit(1); end
                default: begin
                    st = (dp && m == 1) ? 1 : 0;
                    dp = 0;
                end
            endcase
        end
        mSt[m] = st; mDp[m] = dp; mCn[m] = c;
        e.busy = (st >= 1) && (st <= 3);
        e.step = (st == 2) && (c != 8'd0);
        e.done = (st == 4);
        e.cnt  = (m == 1 && dp) ? (c ^ MASK) : c;
        if (m == 0) expQ0.push_back(e);
        else        expQ1.push_back(e);
    endtask

    always @(posedge clk) begin
        if (scoreOn) begin
            obs_t e0, e1;
            modelEdge(0);
            modelEdge(1);
            #1;
            e0 = expQ0.pop_front();
            e1 = expQ1.pop_front();
            vectors++;
            if ({busy0, step0, done0, cnt0} !== e0) begin
                miscompares++;
                $display("[TB] FAIL scoreboard dut0 t=%0t got=%h exp=%h", $time, {busy0, step0, done0, cnt0}, e0);
            end
            vectors++;
            if ({busy1, step1, done1, cnt1} !== e1) begin
                miscompares++;
                $display("[TB] FAIL scoreboard dut1 t=%0t got=%h exp=%h", $time, {busy1, step1, done1, cnt1}, e1);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; pause = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        scoreOn = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({busy0, step0, done0, cnt0, busy1, step1, done1, cnt1} !== 22'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state got=%h exp=0", {busy0, step0, done0, cnt0, busy1, step1, done1, cnt1});
        end
        rst = 1'b0;
    endtask

    task automatic test_golden(input logic [3:0] key, input string tag);
        int busyCnt = 0, stepCnt = 0, doneAt = -1;
        applyReset();
        keyinput = key; len_in = 8'd3; start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            busyCnt += int'(busy0);
            stepCnt += int'(step0);
            if (done0) doneAt = k;
            if (k >= 2 && k <= 5) begin
                vectors++;
                if (cnt0 !== 8'(5 - k)) begin
                    miscompares++;
                    $display("[TB] FAIL %s cnt k=%0d got=%h exp=%h", tag, k, cnt0, 8'(5 - k));
                end
            end
            if (k == 7) begin
                vectors++;
                if (busy0 !== 1'b0 || done0 !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL %s idle_after got busy=%b done=%b exp 0 0", tag, busy0, done0);
                end
            end
        end
        vectors++;
        if (busyCnt != 5 || stepCnt != 3 || doneAt != 6) begin
            miscompares++;
            $display("[TB] FAIL %s counts got busy=%0d step=%0d done@%0d exp 5 3 6", tag, busyCnt, stepCnt, doneAt);
        end
    endtask

    task automatic test_corrupt();
        logic [7:0] tbl[4] = '{8'h59, 8'h58, 8'h5B, 8'h5A};
        int stepCnt = 0;
        applyReset();
        keyinput = 4'b1000; len_in = 8'd3; start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            stepCnt += int'(step1);
            if (k >= 2 && k <= 5) begin
                vectors++;
                if (cnt1 !== tbl[k-2]) begin
                    miscompares++;
                    $display("[TB] FAIL corrupt_cnt k=%0d got=%h exp=%h", k, cnt1, tbl[k-2]);
                end
            end
        end
        vectors++;
        if (stepCnt != 3) begin
            miscompares++;
            $display("[TB] FAIL corrupt_steps got=%0d exp=3", stepCnt);
        end
    endtask

    task automatic test_rerun();
        applyReset();
        keyinput = 4'b0010; len_in = 8'd2; start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 5) begin
                vectors++;
                if (done1 !== 1'b1 || done0 !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL rerun_done got d0=%b d1=%b exp 1 1", done0, done1);
                end
            end
            if (k == 6) begin
                vectors++;
                if (busy1 !== 1'b1 || busy0 !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL rerun_busy got b0=%b b1=%b exp 0 1", busy0, busy1);
                end
            end
            if (k == 7) begin
                vectors++;
                if (cnt1 !== 8'd2 || step1 !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL rerun_second got cnt=%h step=%b exp 02 1", cnt1, step1);
                end
            end
        end
    endtask

    task automatic test_pause();
        applyReset();
        keyinput = KEY_OK; len_in = 8'd5; start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k >= 5 && k <= 8) begin
                vectors++;
                if (busy0 !== 1'b1 || step0 !== 1'b0 || cnt0 !== 8'd3) begin
                    miscompares++;
                    $display("[TB] FAIL pause_hold k=%0d got b=%b s=%b cnt=%h exp 1 0 03", k, busy0, step0, cnt0);
                end
            end
            if (k == 12) begin
                vectors++;
                if (cnt0 !== 8'd0 || step0 !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL pause_zero got cnt=%h step=%b exp 00 0", cnt0, step0);
                end
            end
            if (k == 13) begin
                vectors++;
                if (done0 !== 1'b1 || busy0 !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL pause_done got d=%b b=%b exp 1 0", done0, busy0);
                end
            end
            pause = ((k >= 4) && (k <= 7)) || (k == 12);
        end
        pause = 1'b0;
    endtask

    task automatic test_abort();
        applyReset();
        keyinput = KEY_OK; len_in = 8'd5; start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 5) rst = 1'b1;
            if (k == 6) begin
                rst = 1'b0;
                vectors++;
                if (busy0 !== 1'b0 || cnt0 !== 8'd0 || done0 !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL abort got b=%b cnt=%h d=%b exp 0 00 0", busy0, cnt0, done0);
                end
            end
            if (k > 6) begin
                vectors++;
                if (done0 !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL abort_nodone k=%0d got=%b exp=0", k, done0);
                end
            end
        end
    endtask

    task automatic test_zero_len();
        int stepCnt = 0, doneAt = -1;
        applyReset();
        keyinput = KEY_OK; len_in = 8'd0; start = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            stepCnt += int'(step0);
            if (done0) doneAt = k;
        end
        vectors++;
        if (stepCnt != 0 || doneAt != 3) begin
            miscompares++;
            $display("[TB] FAIL zero_len got steps=%0d done@%0d exp 0 3", stepCnt, doneAt);
        end
    endtask

    task automatic test_back_to_back();
        applyReset();
        keyinput = KEY_OK; len_in = 8'd2; start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 2) len_in = 8'd9;
            if (k == 3) start = 1'b0;
            if (k == 2 || k == 3) begin
                vectors++;
                if (cnt0 !== 8'(4 - k)) begin
                    miscompares++;
                    $display("[TB] FAIL busy_ignore cnt k=%0d got=%h exp=%h", k, cnt0, 8'(4 - k));
                end
            end
            if (k == 5) begin
                vectors++;
                if (done0 !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL busy_ignore done got=%b exp=1", done0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_golden(4'b1010, "golden_key");
        test_golden(4'b0101, "wrong_key_equiv");
        test_corrupt();
        test_rerun();
        test_pause();
        test_abort();
        test_zero_len();
        test_back_to_back();
        applyReset();
        @(negedge clk);
        @(negedge clk);
        scoreOn = 1'b0;
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
